// File: rtl/dac_pkg.sv
// Shared definitions for the serial DAC transmitter: frame width,
// FSM state encodings and DAC121S101 power-down mode codes.
package dac_pkg;

    // One DAC frame: {2'b00, pd_mode[1:0], sample[11:0]}
    localparam int FRAME_W = 16;

    // Width of the bit index that walks 15..0 across a frame
    localparam int BIT_W = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_QUIET = 2'd3
    } dac_state_t;

    // Power-down bits carried in frame[13:12]
    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

endpackage

// File: rtl/dac_sclk_gen.sv
// Half-period timer for the DAC serial clock. While enabled it counts
// CLK_DIV clk cycles per phase and emits a one-cycle tick on the last
// cycle of each phase, reloading itself at that boundary. While disabled
// it sits preloaded so the first phase after enabling is a full CLK_DIV.
module dac_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count down within a phase; reload at the phase boundary or when idle
    always_comb begin
        cnt_d = RELOAD;
        if (en && (cnt_q != CNT_ONE)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_ONE);

endmodule

// File: rtl/dac_serial_tx.sv
// Serial DAC transmitter for DAC121S101-style devices (PmodDA2).
// Accepts one sample per valid/ready handshake, frames it as
// {2'b00, mode, data} and shifts it MSB-first on sync/sclk/din.
// sclk idles high; the DAC samples din on sclk falling edges, so din is
// only updated on sclk rising edges.
// Optional build macro DAC_DUAL_CH_EN adds a second channel (data_b,
// mode_b, din_b) shifted bit-aligned with the first, sharing sync/sclk.
module dac_serial_tx
    import dac_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 4,
    parameter int DATA_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
`ifdef DAC_DUAL_CH_EN
    input  logic [DATA_W-1:0] data_b,
    input  logic [1:0]        mode_b,
    output logic              din_b,
`endif
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              sync,
    output logic              sclk,
    output logic              din
);

    localparam int QCNT_W = $clog2(QUIET_CYC + 1);
    localparam logic [QCNT_W-1:0] QUIET_LOAD = QCNT_W'(QUIET_CYC);
    localparam logic [QCNT_W-1:0] QCNT_ONE   = QCNT_W'(1);
    localparam logic [QCNT_W-1:0] QCNT_TWO   = QCNT_W'(2);
    localparam logic [BIT_W-1:0]  BIT_MSB    = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);

    dac_state_t state_q, state_d;

    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [FRAME_W-1:0] frame_a;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               half_q, half_d;
    logic [QCNT_W-1:0]  qcnt_q, qcnt_d;

    logic sync_q, sync_d;
    logic sclk_q, sclk_d;
    logic din_q,  din_d;
    logic ready_q, ready_d;
    logic busy_q,  busy_d;
    logic done_q,  done_d;

    logic phase_en;
    logic phase_tick;

`ifdef DAC_DUAL_CH_EN
    logic [FRAME_W-1:0] sr_b_q, sr_b_d;
    logic [FRAME_W-1:0] frame_b;
    logic               din_b_q, din_b_d;

    assign frame_b = FRAME_W'({2'b00, mode_b, data_b});
`endif

    assign frame_a = FRAME_W'({2'b00, mode, data});

    // The phase timer only runs while sclk is being generated
    assign phase_en = (state_q == S_SETUP) || (state_q == S_SHIFT);

    dac_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (phase_en),
        .tick  (phase_tick)
    );

    // Next-state and registered-output logic for the frame sequencer
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        half_d  = half_q;
        qcnt_d  = qcnt_q;
        sync_d  = sync_q;
        sclk_d  = sclk_q;
        din_d   = din_q;
        done_d  = 1'b0;
`ifdef DAC_DUAL_CH_EN
        sr_b_d  = sr_b_q;
        din_b_d = din_b_q;
`endif

        case (state_q)
            S_IDLE: begin
                sync_d = 1'b1;
                sclk_d = 1'b1;
                din_d  = 1'b0;
`ifdef DAC_DUAL_CH_EN
                din_b_d = 1'b0;
`endif
                // ready is high exactly in IDLE, so valid alone is an accept
                if (valid) begin
                    state_d = S_SETUP;
                    // MSB goes straight to din; the rest waits in the shifter
                    din_d   = frame_a[FRAME_W-1];
                    sr_d    = {frame_a[FRAME_W-2:0], 1'b0};
                    sync_d  = 1'b0;
                    bit_d   = BIT_MSB;
                    half_d  = 1'b0;
`ifdef DAC_DUAL_CH_EN
                    din_b_d = frame_b[FRAME_W-1];
                    sr_b_d  = {frame_b[FRAME_W-2:0], 1'b0};
`endif
                end
            end

            S_SETUP: begin
                // sync low with sclk high gives the DAC its setup time
                if (phase_tick) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b0;
                    half_d  = 1'b0;
                end
            end

            S_SHIFT: begin
                if (phase_tick) begin
                    if (!half_q) begin
                        // Rising edge: present the next bit for the next fall
                        sclk_d = 1'b1;
                        half_d = 1'b1;
                        din_d  = sr_q[FRAME_W-1];
                        sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
`ifdef DAC_DUAL_CH_EN
                        din_b_d = sr_b_q[FRAME_W-1];
                        sr_b_d  = {sr_b_q[FRAME_W-2:0], 1'b0};
`endif
                    end else if (bit_q == '0) begin
                        state_d = S_QUIET;
                        sync_d  = 1'b1;
                        sclk_d  = 1'b1;
                        din_d   = 1'b0;
                        qcnt_d  = QUIET_LOAD;
                        done_d  = (QUIET_CYC == 1);
`ifdef DAC_DUAL_CH_EN
                        din_b_d = 1'b0;
`endif
                    end else begin
                        // Falling edge: start the low half of the next bit
                        bit_d  = bit_q - BIT_ONE;
                        half_d = 1'b0;
                        sclk_d = 1'b0;
                    end
                end
            end

            S_QUIET: begin
                if (qcnt_q == QCNT_ONE) begin
                    state_d = S_IDLE;
                end else begin
                    qcnt_d = qcnt_q - QCNT_ONE;
                    // done lands on the final quiet cycle
                    done_d = (qcnt_q == QCNT_TWO);
                end
            end

            default: begin
                state_d = S_IDLE;
                sync_d  = 1'b1;
                sclk_d  = 1'b1;
                din_d   = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = !ready_d;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            half_q  <= 1'b0;
            qcnt_q  <= '0;
            sync_q  <= 1'b1;
            sclk_q  <= 1'b1;
            din_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            qcnt_q  <= qcnt_d;
            sync_q  <= sync_d;
            sclk_q  <= sclk_d;
            din_q   <= din_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Frame shift register; always reloaded on accept before it is used
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

`ifdef DAC_DUAL_CH_EN
    // Channel B output bit, cleared with the rest of the serial outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_b_q <= 1'b0;
        end else begin
            din_b_q <= din_b_d;
        end
    end

    // Channel B shift register, latched on the same accept as channel A
    always_ff @(posedge clk) begin
        sr_b_q <= sr_b_d;
    end

    assign din_b = din_b_q;
`endif

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sync  = sync_q;
    assign sclk  = sclk_q;
    assign din   = din_q;

endmodule
